// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline-side signals of the hazard controller; perf counter outputs
// exist only when HAZARD_PERF_CNT_EN is defined.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5
`ifdef HAZARD_PERF_CNT_EN
  , parameter int STALL_CNT_W = 16
`endif
);
  logic [REG_AW-1:0] id_rs, id_rt, ex_rd, ex_rs, ex_rt, mem_rd, wb_rd;
  logic id_use_rs, id_use_rt, id_is_branch, id_redirect;
  logic ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite, ext_stall;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a_id, fwd_b_id;
  logic [1:0] fwd_a_ex, fwd_b_ex, state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cycles, flush_count;
`endif
  modport master (
    output id_rs, id_rt, ex_rd, ex_rs, ex_rt, mem_rd, wb_rd,
    output id_use_rs, id_use_rt, id_is_branch, id_redirect,
    output ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite, ext_stall,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a_id, fwd_b_id,
    input  fwd_a_ex, fwd_b_ex, state_o
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cycles, flush_count
`endif
  );
  modport slave (
    input  id_rs, id_rt, ex_rd, ex_rs, ex_rt, mem_rd, wb_rd,
    input  id_use_rs, id_use_rt, id_is_branch, id_redirect,
    input  ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite, ext_stall,
    output pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a_id, fwd_b_id,
    output fwd_a_ex, fwd_b_ex, state_o
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cycles, flush_count
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencing and forwarding selects for a 5-stage pipeline.
// Define HAZARD_PERF_CNT_EN to add saturating stall_cycles / flush_count counters.
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 5
`ifdef HAZARD_PERF_CNT_EN
  , parameter int STALL_CNT_W = 16
`endif
) (
  input  logic clk,
  input  logic rst_n,
  pipeline_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'b00, STALL1 = 2'b01, FREEZE = 2'b10} state_e;
  state_e state_q, state_d;
  logic ld_ex, alu_ex, ld_mem, need2, need_any, freeze, stall;
  function automatic logic hit(logic [REG_AW-1:0] prod, logic en, logic [REG_AW-1:0] cons, logic use_f);
    return en && use_f && prod != '0 && prod == cons;
  endfunction
  always_comb begin
    ld_ex    = hit(bus.ex_rd, bus.ex_memread, bus.id_rs, bus.id_use_rs)
             | hit(bus.ex_rd, bus.ex_memread, bus.id_rt, bus.id_use_rt);
    alu_ex   = hit(bus.ex_rd, bus.ex_regwrite & ~bus.ex_memread, bus.id_rs, bus.id_use_rs)
             | hit(bus.ex_rd, bus.ex_regwrite & ~bus.ex_memread, bus.id_rt, bus.id_use_rt);
    ld_mem   = hit(bus.mem_rd, bus.mem_memread, bus.id_rs, bus.id_use_rs)
             | hit(bus.mem_rd, bus.mem_memread, bus.id_rt, bus.id_use_rt);
    need2    = bus.id_is_branch & ld_ex;
    need_any = bus.id_is_branch ? (ld_ex | alu_ex | ld_mem) : ld_ex;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  // FREEZE with ext_stall low behaves exactly like RUN, so only STALL1 suppresses re-evaluation
  always_comb
    state_d = bus.ext_stall ? FREEZE : (state_q != STALL1 && need2) ? STALL1 : RUN;
  always_comb begin
    freeze          = bus.ext_stall;
    stall           = !freeze && (state_q == STALL1 || need_any);
    bus.pc_write    = !freeze && !stall;
    bus.ifid_write  = !freeze && !stall;
    bus.idex_bubble = stall;
    bus.ifid_flush  = !freeze && !stall && bus.id_redirect;
    bus.state_o     = state_q;
  end
  always_comb begin
    bus.fwd_a_ex = hit(bus.mem_rd, bus.mem_regwrite & ~bus.mem_memread, bus.ex_rs, 1'b1) ? 2'b10 :
                   hit(bus.wb_rd, bus.wb_regwrite, bus.ex_rs, 1'b1) ? 2'b01 : 2'b00;
    bus.fwd_b_ex = hit(bus.mem_rd, bus.mem_regwrite & ~bus.mem_memread, bus.ex_rt, 1'b1) ? 2'b10 :
                   hit(bus.wb_rd, bus.wb_regwrite, bus.ex_rt, 1'b1) ? 2'b01 : 2'b00;
    bus.fwd_a_id = hit(bus.mem_rd, bus.mem_regwrite & ~bus.mem_memread, bus.id_rs, 1'b1);
    bus.fwd_b_id = hit(bus.mem_rd, bus.mem_regwrite & ~bus.mem_memread, bus.id_rt, 1'b1);
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.idex_bubble && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
      if (bus.ifid_flush && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + STALL_CNT_W'(1);
    end
  assign bus.stall_cycles = stall_cnt_q;
  assign bus.flush_count  = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed pipeline scenarios with a stall-count model checked every cycle.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
`ifdef HAZARD_PERF_CNT_EN
  pipeline_hazard_ctrl_if #(.REG_AW(5), .STALL_CNT_W(16)) bus ();
  pipeline_hazard_ctrl #(.REG_AW(5), .STALL_CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
  pipeline_hazard_ctrl_if #(.REG_AW(5)) bus ();
  pipeline_hazard_ctrl #(.REG_AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask
  function automatic bit m(logic [4:0] p, logic en, logic [4:0] c, logic u);
    return en && u && p != 0 && p == c;
  endfunction
  function automatic int need_n();
    int n = 0;
    int c;
    logic [4:0] op [2];
    logic us [2];
    op[0] = bus.id_rs; op[1] = bus.id_rt;
    us[0] = bus.id_use_rs; us[1] = bus.id_use_rt;
    for (int i = 0; i < 2; i++) begin
      c = 0;
      if (m(bus.ex_rd, bus.ex_memread, op[i], us[i])) c = bus.id_is_branch ? 2 : 1;
      else if (bus.id_is_branch && (m(bus.ex_rd, bus.ex_regwrite, op[i], us[i]) ||
               m(bus.mem_rd, bus.mem_memread, op[i], us[i]))) c = 1;
      if (c > n) n = c;
    end
    return n;
  endfunction
  function automatic int fex(logic [4:0] r);
    if (bus.mem_regwrite && !bus.mem_memread && bus.mem_rd != 0 && bus.mem_rd == r) return 2;
    if (bus.wb_regwrite && bus.wb_rd != 0 && bus.wb_rd == r) return 1;
    return 0;
  endfunction
  function automatic int fid(logic [4:0] r);
    return (bus.mem_regwrite && !bus.mem_memread && bus.mem_rd != 0 && bus.mem_rd == r) ? 1 : 0;
  endfunction
  // model: pend = forced stall cycles still owed, frozen = previous cycle was held by ext_stall
  int pend, frozen, pend_n, frozen_n, cnt_s, cnt_f;
  bit exp_bub, exp_fl;
  always @(negedge clk) begin
    int n;
    bit frz, stl;
    if (!rst_n) begin
      pend_n <= 0; frozen_n <= 0; exp_bub <= 0; exp_fl <= 0;
    end else begin
      frz = bus.ext_stall;
      n = need_n();
      stl = !frz && (pend > 0 || n > 0);
      chk("state_o", bus.state_o, frozen ? 2 : (pend > 0 ? 1 : 0));
      chk("pc_write", bus.pc_write, !frz && !stl);
      chk("ifid_write", bus.ifid_write, !frz && !stl);
      chk("idex_bubble", bus.idex_bubble, stl);
      chk("ifid_flush", bus.ifid_flush, !frz && !stl && bus.id_redirect);
      chk("fwd_a_ex", bus.fwd_a_ex, fex(bus.ex_rs));
      chk("fwd_b_ex", bus.fwd_b_ex, fex(bus.ex_rt));
      chk("fwd_a_id", bus.fwd_a_id, fid(bus.id_rs));
      chk("fwd_b_id", bus.fwd_b_id, fid(bus.id_rt));
`ifdef HAZARD_PERF_CNT_EN
      chk("stall_cycles", bus.stall_cycles, cnt_s);
      chk("flush_count", bus.flush_count, cnt_f);
`endif
      pend_n <= (frz || pend > 0 || n == 0) ? 0 : n - 1;
      frozen_n <= frz;
      exp_bub <= stl;
      exp_fl <= !frz && !stl && bus.id_redirect;
    end
  end
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend <= 0; frozen <= 0; cnt_s <= 0; cnt_f <= 0;
    end else begin
      pend <= pend_n;
      frozen <= frozen_n;
      if (exp_bub && cnt_s != 16'hFFFF) cnt_s <= cnt_s + 1;
      if (exp_fl && cnt_f != 16'hFFFF) cnt_f <= cnt_f + 1;
    end
  task automatic nop();
    {bus.id_rs, bus.id_rt, bus.ex_rd, bus.ex_rs, bus.ex_rt, bus.mem_rd, bus.wb_rd} = '0;
    {bus.id_use_rs, bus.id_use_rt, bus.id_is_branch, bus.id_redirect} = '0;
    {bus.ex_regwrite, bus.ex_memread, bus.mem_regwrite, bus.mem_memread, bus.wb_regwrite, bus.ext_stall} = '0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic lw5_beq5();
    nop();
    bus.ex_memread = 1; bus.ex_regwrite = 1; bus.ex_rd = 5;
    bus.id_is_branch = 1; bus.id_rs = 5; bus.id_rt = 6; bus.id_use_rs = 1; bus.id_use_rt = 1;
  endtask
  task automatic lw5_to_mem();
    bus.ex_memread = 0; bus.ex_regwrite = 0; bus.ex_rd = 0;
    bus.mem_rd = 5; bus.mem_regwrite = 1; bus.mem_memread = 1;
  endtask
  initial begin
    nop();
    repeat (2) @(posedge clk);
    #1;
    chk("rst pc_write", bus.pc_write, 1);
    chk("rst ifid_write", bus.ifid_write, 1);
    chk("rst ifid_flush", bus.ifid_flush, 0);
    chk("rst idex_bubble", bus.idex_bubble, 0);
    chk("rst state_o", bus.state_o, 0);
    chk("rst fwd_a_ex", bus.fwd_a_ex, 0);
    rst_n = 1;
    // load-use: lw $2 in EX, add $3,$2,$4 in ID
    bus.ex_memread = 1; bus.ex_regwrite = 1; bus.ex_rd = 2;
    bus.id_rs = 2; bus.id_use_rs = 1; bus.id_rt = 4; bus.id_use_rt = 1;
    @(negedge clk);
    chk("lu pc_write", bus.pc_write, 0);
    chk("lu bubble", bus.idex_bubble, 1);
    step();
    bus.ex_memread = 0; bus.ex_regwrite = 0; bus.ex_rd = 0;
    bus.mem_rd = 2; bus.mem_regwrite = 1; bus.mem_memread = 1;
    @(negedge clk);
    chk("lu resume pc_write", bus.pc_write, 1);
    chk("lu resume bubble", bus.idex_bubble, 0);
    step();
    nop();
    bus.ex_rs = 2; bus.ex_rt = 4; bus.ex_rd = 3; bus.ex_regwrite = 1;
    bus.wb_rd = 2; bus.wb_regwrite = 1;
    @(negedge clk);
    chk("lu fwd_a_ex", bus.fwd_a_ex, 1);
    chk("lu fwd_b_ex", bus.fwd_b_ex, 0);
    // lw $5 then beq $5,$6: two stall cycles
    step();
    lw5_beq5();
    @(negedge clk);
    chk("br2 state0", bus.state_o, 0);
    chk("br2 bubble0", bus.idex_bubble, 1);
    step();
    lw5_to_mem();
    @(negedge clk);
    chk("br2 state1", bus.state_o, 1);
    chk("br2 pc_write1", bus.pc_write, 0);
    step();
    bus.mem_rd = 0; bus.mem_regwrite = 0; bus.mem_memread = 0;
    bus.wb_rd = 5; bus.wb_regwrite = 1; bus.id_redirect = 1;
    @(negedge clk);
    chk("br2 state2", bus.state_o, 0);
    chk("br2 fwd_a_id", bus.fwd_a_id, 0);
    chk("br2 flush", bus.ifid_flush, 1);
    step();
    nop();
    @(negedge clk);
    chk("br2 flush off", bus.ifid_flush, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf stall_cycles", bus.stall_cycles, 3);
    chk("perf flush_count", bus.flush_count, 1);
`endif
    // add $7 then beq $7,$0: one stall, redirect ignored while stalled
    step();
    nop();
    bus.ex_regwrite = 1; bus.ex_rd = 7;
    bus.id_is_branch = 1; bus.id_rs = 7; bus.id_rt = 0; bus.id_use_rs = 1; bus.id_use_rt = 1;
    bus.id_redirect = 1;
    @(negedge clk);
    chk("br1 bubble", bus.idex_bubble, 1);
    chk("br1 flush masked", bus.ifid_flush, 0);
    step();
    bus.ex_regwrite = 0; bus.ex_rd = 0; bus.mem_rd = 7; bus.mem_regwrite = 1;
    @(negedge clk);
    chk("br1 state", bus.state_o, 0);
    chk("br1 fwd_a_id", bus.fwd_a_id, 1);
    chk("br1 fwd_b_id", bus.fwd_b_id, 0);
    chk("br1 flush", bus.ifid_flush, 1);
    // EX forwarding priority and $0
    step();
    nop();
    bus.mem_rd = 8; bus.mem_regwrite = 1; bus.wb_rd = 8; bus.wb_regwrite = 1;
    bus.ex_rs = 8; bus.ex_rt = 8;
    @(negedge clk);
    chk("fwd prio a", bus.fwd_a_ex, 2);
    chk("fwd prio b", bus.fwd_b_ex, 2);
    step();
    bus.mem_memread = 1;
    @(negedge clk);
    chk("fwd load in mem", bus.fwd_a_ex, 1);
    step();
    bus.mem_memread = 0; bus.mem_rd = 0; bus.wb_rd = 0;
    @(negedge clk);
    chk("fwd r0 a", bus.fwd_a_ex, 0);
    chk("fwd r0 b", bus.fwd_b_ex, 0);
    // ext_stall held 3 cycles starting in STALL1
    step();
    lw5_beq5();
    step();
    lw5_to_mem();
    bus.ext_stall = 1;
    @(negedge clk);
    chk("frz state1", bus.state_o, 1);
    chk("frz pc_write", bus.pc_write, 0);
    chk("frz bubble", bus.idex_bubble, 0);
    step();
    @(negedge clk);
    chk("frz state2", bus.state_o, 2);
    step();
    @(negedge clk);
    chk("frz bubble3", bus.idex_bubble, 0);
    step();
    bus.ext_stall = 0;
    @(negedge clk);
    chk("frz exit state", bus.state_o, 2);
    chk("frz exit bubble", bus.idex_bubble, 1);
    step();
    bus.mem_rd = 0; bus.mem_regwrite = 0; bus.mem_memread = 0;
    bus.wb_rd = 5; bus.wb_regwrite = 1;
    @(negedge clk);
    chk("frz resume pc_write", bus.pc_write, 1);
    // async reset in the middle of a two-cycle stall
    step();
    lw5_beq5();
    step();
    lw5_to_mem();
    @(negedge clk);
    chk("ar pre state", bus.state_o, 1);
    #2;
    rst_n = 0;
    nop();
    #1;
    chk("ar pc_write", bus.pc_write, 1);
    chk("ar state", bus.state_o, 0);
    chk("ar bubble", bus.idex_bubble, 0);
    step();
    step();
    rst_n = 1;
    @(negedge clk);
    chk("ar after state", bus.state_o, 0);
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
